// File: rtl/r2r_pkg.sv
// Shared types and default sizes for the R2R waveform generator.
package r2r_pkg;

    typedef enum logic [1:0] {
        EXT  = 2'd0,
        RAMP = 2'd1,
        TRI  = 2'd2,
        SQR  = 2'd3
    } mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DIV_WIDTH = 8;

endpackage

// File: rtl/r2r_clk_div.sv
// Loadable down-counting divider; tick is high while the count sits at zero.
module r2r_clk_div
    import r2r_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_val,
    input  logic                 restart,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] reload_q, reload_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        reload_d = reload_q;
        cnt_d    = cnt_q;
        if (load) begin
            reload_d = load_val;
            cnt_d    = load_val;
        end else if (restart || cnt_q == '0) begin
            cnt_d = reload_q;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the edge.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            reload_q <= '0;
            cnt_q    <= '0;
        end else begin
            reload_q <= reload_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/r2r_wave_gen.sv
// R2R DAC code generator: external data, ramp, triangle or square from a phase accumulator.
module r2r_wave_gen
    import r2r_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             load_divider,
    input  logic             load_step,
    output logic [WIDTH-1:0] r2r_out,
    output logic             cnt_zero,
    output logic             period_done
);

    localparam logic [WIDTH-1:0] MAX = '1;

    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             pd_q, pd_d;
    logic             mode_chg;
    logic             tick;
    logic             upd;
    logic [WIDTH:0]   sum;

    r2r_clk_div #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_clk_div (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (load_divider),
        .load_val(data[DIV_WIDTH-1:0]),
        .restart (mode_chg),
        .tick    (tick)
    );

    assign mode_d   = mode_e'(mode);
    assign mode_chg = (mode_d != mode_q);
    // A divider load or mode change owns the edge; the tick is swallowed.
    assign upd      = tick && !load_divider && !mode_chg && (step_q != '0) && (mode_q != EXT);
    assign sum      = {1'b0, acc_q} + {1'b0, step_q};

    always_comb begin
        acc_d  = acc_q;
        dir_d  = dir_q;
        pd_d   = 1'b0;
        step_d = load_step ? data : step_q;
        if (mode_chg) begin
            acc_d = '0;
            dir_d = UP;
        end else if (upd) begin
            unique case (mode_q)
                RAMP, SQR: begin
                    acc_d = sum[WIDTH-1:0];
                    pd_d  = sum[WIDTH];
                end
                TRI: begin
                    if (dir_q == UP) begin
                        if (acc_q >= MAX - step_q) begin
                            acc_d = MAX;
                            dir_d = DOWN;
                        end else begin
                            acc_d = acc_q + step_q;
                        end
                    end else if (acc_q <= step_q) begin
                        acc_d = '0;
                        dir_d = UP;
                        pd_d  = 1'b1;
                    end else begin
                        acc_d = acc_q - step_q;
                    end
                end
                default: ;
            endcase
        end

        unique case (mode_d)
            EXT:       out_d = data;
            SQR:       out_d = acc_d[WIDTH-1] ? MAX : '0;
            default:   out_d = acc_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mode_q <= EXT;
            dir_q  <= UP;
            acc_q  <= '0;
            step_q <= WIDTH'(1);
            out_q  <= '0;
            pd_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            acc_q  <= acc_d;
            step_q <= step_d;
            out_q  <= out_d;
            pd_q   <= pd_d;
        end
    end

    assign r2r_out     = out_q;
    assign period_done = pd_q;
    assign cnt_zero    = tick;

endmodule

// File: tb/tb_r2r_wave_gen.sv
// Directed bench for r2r_wave_gen: vector table plus full-period waveform sequences.
module tb_r2r_wave_gen;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [1:0] mode;
    logic [7:0] data;
    logic       load_divider;
    logic       load_step;
    logic [7:0] r2r_out;
    logic       cnt_zero;
    logic       period_done;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       rst_n;
        logic [1:0] mode;
        logic [7:0] data;
        logic       ld_div;
        logic       ld_step;
        logic [7:0] exp_out;
        logic       exp_cz;
        logic       exp_pd;
    } vec_t;

    localparam int NVEC = 39;
    vec_t vecs [NVEC];

    r2r_wave_gen #(.WIDTH(8), .DIV_WIDTH(8)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .mode        (mode),
        .data        (data),
        .load_divider(load_divider),
        .load_step   (load_step),
        .r2r_out     (r2r_out),
        .cnt_zero    (cnt_zero),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic edge_in(input logic r, input logic [1:0] m, input logic [7:0] d,
                           input logic ldd, input logic lds);
        @(negedge clk);
        n_rst        = r;
        mode         = m;
        data         = d;
        load_divider = ldd;
        load_step    = lds;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pd_cnt, zeros, highs;

        n_rst = 1'b0; mode = 2'd0; data = 8'h00; load_divider = 1'b0; load_step = 1'b0;

        //           rst mode data  ldd lds  out   cz   pd
        vecs[0]  = '{0, 2'd0, 8'h00, 0, 0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1, 2'd0, 8'hA5, 0, 0, 8'hA5, 1'b1, 1'b0};
        vecs[2]  = '{1, 2'd0, 8'h3C, 0, 0, 8'h3C, 1'b1, 1'b0};
        vecs[3]  = '{1, 2'd1, 8'h00, 0, 0, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1, 2'd1, 8'h00, 0, 0, 8'h01, 1'b1, 1'b0};
        vecs[5]  = '{1, 2'd1, 8'h00, 0, 0, 8'h02, 1'b1, 1'b0};
        vecs[6]  = '{1, 2'd1, 8'h05, 0, 1, 8'h03, 1'b1, 1'b0};
        vecs[7]  = '{1, 2'd1, 8'h00, 0, 0, 8'h08, 1'b1, 1'b0};
        vecs[8]  = '{1, 2'd1, 8'h00, 0, 1, 8'h0D, 1'b1, 1'b0};
        vecs[9]  = '{1, 2'd1, 8'h00, 0, 0, 8'h0D, 1'b1, 1'b0};
        vecs[10] = '{1, 2'd2, 8'd100, 0, 1, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1, 2'd2, 8'h00, 0, 0, 8'd100, 1'b1, 1'b0};
        vecs[12] = '{1, 2'd2, 8'h00, 0, 0, 8'd200, 1'b1, 1'b0};
        vecs[13] = '{1, 2'd2, 8'h00, 0, 0, 8'd255, 1'b1, 1'b0};
        vecs[14] = '{1, 2'd2, 8'h00, 0, 0, 8'd155, 1'b1, 1'b0};
        vecs[15] = '{1, 2'd2, 8'h00, 0, 0, 8'd55,  1'b1, 1'b0};
        vecs[16] = '{1, 2'd2, 8'h00, 0, 0, 8'd0,   1'b1, 1'b1};
        vecs[17] = '{1, 2'd2, 8'h00, 0, 0, 8'd100, 1'b1, 1'b0};
        vecs[18] = '{0, 2'd2, 8'h00, 0, 0, 8'h00, 1'b1, 1'b0};
        vecs[19] = '{1, 2'd2, 8'h00, 0, 0, 8'h00, 1'b1, 1'b0};
        vecs[20] = '{1, 2'd2, 8'h00, 0, 0, 8'h01, 1'b1, 1'b0};
        vecs[21] = '{1, 2'd3, 8'h00, 0, 0, 8'h00, 1'b1, 1'b0};
        vecs[22] = '{1, 2'd3, 8'h00, 0, 0, 8'h00, 1'b1, 1'b0};
        vecs[23] = '{1, 2'd0, 8'h77, 0, 0, 8'h77, 1'b1, 1'b0};
        vecs[24] = '{1, 2'd0, 8'h03, 1, 0, 8'h03, 1'b0, 1'b0};
        vecs[25] = '{1, 2'd1, 8'h00, 0, 0, 8'h00, 1'b0, 1'b0};
        vecs[26] = '{1, 2'd1, 8'h00, 0, 0, 8'h00, 1'b0, 1'b0};
        vecs[27] = '{1, 2'd1, 8'h00, 0, 0, 8'h00, 1'b0, 1'b0};
        vecs[28] = '{1, 2'd1, 8'h00, 0, 0, 8'h00, 1'b1, 1'b0};
        vecs[29] = '{1, 2'd1, 8'h00, 0, 0, 8'h01, 1'b0, 1'b0};
        vecs[30] = '{1, 2'd1, 8'h00, 0, 0, 8'h01, 1'b0, 1'b0};
        vecs[31] = '{1, 2'd1, 8'h00, 0, 0, 8'h01, 1'b0, 1'b0};
        vecs[32] = '{1, 2'd1, 8'h00, 0, 0, 8'h01, 1'b1, 1'b0};
        vecs[33] = '{1, 2'd1, 8'h00, 0, 0, 8'h02, 1'b0, 1'b0};
        vecs[34] = '{1, 2'd1, 8'h00, 0, 0, 8'h02, 1'b0, 1'b0};
        vecs[35] = '{1, 2'd1, 8'h00, 0, 0, 8'h02, 1'b0, 1'b0};
        vecs[36] = '{1, 2'd1, 8'h00, 0, 0, 8'h02, 1'b1, 1'b0};
        vecs[37] = '{1, 2'd1, 8'h00, 1, 0, 8'h02, 1'b1, 1'b0};
        vecs[38] = '{1, 2'd1, 8'h00, 0, 0, 8'h03, 1'b1, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            edge_in(vecs[i].rst_n, vecs[i].mode, vecs[i].data, vecs[i].ld_div, vecs[i].ld_step);
            check($sformatf("vec%0d_out", i), r2r_out,     vecs[i].exp_out);
            check($sformatf("vec%0d_cz",  i), cnt_zero,    vecs[i].exp_cz);
            check($sformatf("vec%0d_pd",  i), period_done, vecs[i].exp_pd);
        end

        // Full ramp period, step 1, divider 0.
        edge_in(0, 2'd0, 8'h00, 0, 0);
        edge_in(1, 2'd1, 8'h00, 0, 0);
        check("ramp_start", r2r_out, 0);
        for (int k = 0; k < 256; k++) begin
            edge_in(1, 2'd1, 8'h00, 0, 0);
            check($sformatf("ramp%0d_out", k), r2r_out, (k + 1) % 256);
            check($sformatf("ramp%0d_pd", k), period_done, (k == 255) ? 1 : 0);
        end

        // Full triangle period, step 1: 2*255 ticks, one completion pulse.
        edge_in(1, 2'd2, 8'h00, 0, 0);
        check("tri_start", r2r_out, 0);
        pd_cnt = 0;
        for (int k = 1; k <= 510; k++) begin
            edge_in(1, 2'd2, 8'h00, 0, 0);
            if (period_done) pd_cnt++;
            if (k == 255) check("tri_peak", r2r_out, 255);
            if (k == 509) check("tri_before_end", r2r_out, 1);
        end
        check("tri_end_out", r2r_out, 0);
        check("tri_end_pd", period_done, 1);
        check("tri_pd_count", pd_cnt, 1);

        // Square period, step 1: 128 ticks low, 128 ticks high.
        edge_in(1, 2'd3, 8'h00, 0, 0);
        check("sqr_start", r2r_out, 0);
        zeros = 0;
        highs = 0;
        for (int k = 1; k <= 256; k++) begin
            edge_in(1, 2'd3, 8'h00, 0, 0);
            if (r2r_out == 8'h00) zeros++;
            else if (r2r_out == 8'hFF) highs++;
        end
        check("sqr_end_pd", period_done, 1);
        check("sqr_zeros", zeros, 128);
        check("sqr_highs", highs, 128);
        for (int k = 1; k <= 200; k++) edge_in(1, 2'd3, 8'h00, 0, 0);
        check("sqr_mid_high", r2r_out, 255);
        edge_in(1, 2'd1, 8'h00, 0, 0);
        check("sqr_to_ramp_out", r2r_out, 0);
        check("sqr_to_ramp_pd", period_done, 0);
        edge_in(1, 2'd1, 8'h00, 0, 0);
        check("sqr_to_ramp_next", r2r_out, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
